centroid_tracker: RTL and testbench



---
 rtl/centroid_pkg.sv | 19 +
 rtl/seq_divider.sv | 62 ++++++
 rtl/centroid_tracker.sv | 133 +++++++++++++
 tb/tb_centroid_tracker.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/centroid_pkg.sv
// Shared types and widths for the centroid tracker slice.
// Frame geometry is 640x480; widths below are sized for a full-frame hit count.
package centroid_pkg;

  localparam int X_W     = 10;
  localparam int Y_W     = 9;
  localparam int SUM_W   = 28;
  localparam int CNT_W   = 19;
  localparam int FRAME_W = 640;
  localparam int FRAME_H = 480;

  typedef enum logic [1:0] {
    IDLE,
    DIV_X,
    DIV_Y,
    UPDATE
  } state_e;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses DVD_W cycles after start.
// The first bit is resolved on the start edge, so quotient is valid while done is high.
module seq_divider #(
  parameter int DVD_W = 28,
  parameter int DVS_W = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);

  localparam int CW = $clog2(DVD_W + 1);

  logic [DVS_W-1:0] rem, dvs, src_r, src_d, rem_n;
  logic [DVD_W-1:0] q, src_q, q_n;
  logic [DVS_W:0]   trial;
  logic [CW-1:0]    steps_left;

  // The same step datapath serves both the load cycle and the iterating cycles.
  always_comb begin
    src_r = start ? '0 : rem;
    src_q = start ? dividend : q;
    src_d = start ? divisor : dvs;
    trial = {src_r, src_q[DVD_W-1]};
    rem_n = trial[DVS_W-1:0];
    q_n   = {src_q[DVD_W-2:0], 1'b0};
    if (trial >= {1'b0, src_d}) begin
      rem_n  = DVS_W'(trial - {1'b0, src_d});
      q_n[0] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem        <= '0;
      dvs        <= '0;
      q          <= '0;
      steps_left <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem        <= rem_n;
        q          <= q_n;
        dvs        <= divisor;
        steps_left <= CW'(DVD_W - 1);
      end else if (steps_left != '0) begin
        rem        <= rem_n;
        q          <= q_n;
        steps_left <= steps_left - CW'(1);
        done       <= (steps_left == CW'(1));
      end
    end
  end

  assign quotient = q;

endmodule

// File: rtl/centroid_tracker.sv
// Per-frame hit centroid: accumulate, snapshot at frame_end, divide, hold result on xdata/ydata.
// upd at frame_end+2+2*SUM_W (frame_end+1 below MIN_HITS); no backpressure, a frame closing while busy is dropped.
module centroid_tracker
  import centroid_pkg::*;
#(
  parameter int X_W      = centroid_pkg::X_W,
  parameter int Y_W      = centroid_pkg::Y_W,
  parameter int SUM_W    = centroid_pkg::SUM_W,
  parameter int CNT_W    = centroid_pkg::CNT_W,
  parameter int MIN_HITS = 16,
  parameter int X_RST    = 320,
  parameter int Y_RST    = 240
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pix_valid,
  input  logic [X_W-1:0] pix_x,
  input  logic [Y_W-1:0] pix_y,
  input  logic           pix_hit,
  input  logic           frame_end,
  output logic [X_W-1:0] xdata,
  output logic [Y_W-1:0] ydata,
  output logic           found,
  output logic           upd,
  output logic           busy,
  output logic           overrun
);

  localparam int AW = SUM_W + 1;
  localparam int CW = CNT_W + 1;

  typedef struct packed {
    logic [SUM_W-1:0] sum_x;
    logic [SUM_W-1:0] sum_y;
    logic [CNT_W-1:0] cnt;
  } acc_t;

  acc_t             acc, closing, snap;
  state_e           state;
  logic             hit;
  logic [AW-1:0]    add_x, add_y;
  logic [CW-1:0]    add_c;
  logic [X_W-1:0]   qx;
  logic             div_start, div_done;
  logic [SUM_W-1:0] div_dividend, div_q;
  logic [CNT_W-1:0] div_divisor;
  logic             unused_q_bits;

  assign hit = pix_valid & pix_hit;

  // closing = accumulators including this cycle's hit; it is both the next
  // accumulator value and what a coincident frame_end snapshots.
  always_comb begin
    add_x   = {1'b0, acc.sum_x} + AW'(pix_x);
    add_y   = {1'b0, acc.sum_y} + AW'(pix_y);
    add_c   = {1'b0, acc.cnt} + CW'(1);
    closing = acc;
    if (hit) begin
      closing.sum_x = add_x[SUM_W] ? '1 : add_x[SUM_W-1:0];
      closing.sum_y = add_y[SUM_W] ? '1 : add_y[SUM_W-1:0];
      closing.cnt   = add_c[CNT_W] ? '1 : add_c[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || frame_end) acc <= '0;
    else                    acc <= closing;
  end

  assign div_start    = (state == IDLE && frame_end && closing.cnt >= CNT_W'(MIN_HITS)) ||
                        (state == DIV_X && div_done);
  assign div_dividend = (state == IDLE) ? closing.sum_x : snap.sum_y;
  assign div_divisor  = (state == IDLE) ? closing.cnt : snap.cnt;

  seq_divider #(
    .DVD_W (SUM_W),
    .DVS_W (CNT_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      snap    <= '0;
      qx      <= '0;
      xdata   <= X_W'(X_RST);
      ydata   <= Y_W'(Y_RST);
      found   <= 1'b0;
      upd     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      upd     <= 1'b0;
      overrun <= frame_end && (state != IDLE);
      case (state)
        IDLE: if (frame_end) begin
          snap <= closing;
          if (closing.cnt < CNT_W'(MIN_HITS)) begin
            upd   <= 1'b1;
            found <= 1'b0;
          end else begin
            state <= DIV_X;
          end
        end
        DIV_X: if (div_done) begin
          qx    <= div_q[X_W-1:0];
          state <= DIV_Y;
        end
        DIV_Y: if (div_done) state <= UPDATE;
        UPDATE: begin
          xdata <= qx;
          ydata <= div_q[Y_W-1:0];
          found <= 1'b1;
          upd   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // Quotients never exceed the frame coordinates, so the high bits are always zero.
  assign unused_q_bits = ^div_q[SUM_W-1:X_W];

endmodule

// File: tb/tb_centroid_tracker.sv
// Self-checking bench for centroid_tracker: randomized pixel streams against a
// sum/count reference model of each frame's hits.
module tb_centroid_tracker;

  localparam int LAT = 2 + 2 * 28;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_valid = 1'b0;
  logic       pix_hit = 1'b0;
  logic       frame_end = 1'b0;
  logic [9:0] pix_x = '0;
  logic [8:0] pix_y = '0;
  logic [9:0] xdata;
  logic [8:0] ydata;
  logic       found, upd, busy, overrun;

  centroid_tracker dut (
    .clk       (clk),
    .reset     (reset),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_hit   (pix_hit),
    .frame_end (frame_end),
    .xdata     (xdata),
    .ydata     (ydata),
    .found     (found),
    .upd       (upd),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: hits of the open frame and the currently expected outputs.
  int hx[$];
  int hy[$];
  int exp_x = 320;
  int exp_y = 240;
  bit exp_found = 1'b0;
  int exp_lat = 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_hit(input int x, input int y);
    pix_valid = 1'b1;
    pix_hit   = 1'b1;
    pix_x     = 10'(x);
    pix_y     = 9'(y);
    hx.push_back(x);
    hy.push_back(y);
    step();
    pix_valid = 1'b0;
    pix_hit   = 1'b0;
  endtask

  task automatic send_noise();
    int m;
    m = $urandom_range(0, 2);
    pix_valid = (m == 0);
    pix_hit   = (m == 1);
    pix_x     = 10'($urandom_range(0, 639));
    pix_y     = 9'($urandom_range(0, 479));
    step();
    pix_valid = 1'b0;
    pix_hit   = 1'b0;
  endtask

  task automatic model_close();
    longint sx = 0;
    longint sy = 0;
    int n;
    n = hx.size();
    foreach (hx[i]) begin
      sx += hx[i];
      sy += hy[i];
    end
    exp_found = (n >= 16);
    exp_lat   = (n >= 16) ? LAT : 1;
    if (n >= 16) begin
      exp_x = int'(sx / n);
      exp_y = int'(sy / n);
    end
    hx.delete();
    hy.delete();
  endtask

  task automatic test_reset();
    int bad_act = 0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (upd || busy || overrun) bad_act++;
    end
    n_cmp++; if (xdata !== 10'd320) begin n_bad++; $display("FAIL rst_x: got %0d want 320", xdata); end
    n_cmp++; if (ydata !== 9'd240) begin n_bad++; $display("FAIL rst_y: got %0d want 240", ydata); end
    n_cmp++; if (found !== 1'b0) begin n_bad++; $display("FAIL rst_found: got %0b want 0", found); end
    n_cmp++; if (bad_act !== 0) begin n_bad++; $display("FAIL rst_activity: got %0d active cycles want 0", bad_act); end
  endtask

  task automatic test_block_centroid();
    int old_x, old_y;
    int first_upd = -1, n_upd = 0, early_chg = 0, late_chg = 0, busy_bad = 0;
    old_x = exp_x;
    old_y = exp_y;
    for (int y = 50; y <= 53; y++)
      for (int x = 100; x <= 103; x++) begin
        if ($urandom_range(0, 1) == 1) send_noise();
        send_hit(x, y);
      end
    frame_end = 1'b1;
    model_close();
    for (int k = 1; k <= 80; k++) begin
      step();
      if (k == 1) frame_end = 1'b0;
      if (upd) begin n_upd++; if (first_upd < 0) first_upd = k; end
      if (first_upd < 0 && (xdata !== 10'(old_x) || ydata !== 9'(old_y))) early_chg++;
      if (first_upd >= 0 && (xdata !== 10'(exp_x) || ydata !== 9'(exp_y))) late_chg++;
      if (busy !== (k < LAT)) busy_bad++;
    end
    n_cmp++; if (first_upd !== LAT) begin n_bad++; $display("FAIL blk_latency: got %0d want %0d", first_upd, LAT); end
    n_cmp++; if (n_upd !== 1) begin n_bad++; $display("FAIL blk_upd_count: got %0d want 1", n_upd); end
    n_cmp++; if (xdata !== 10'd101) begin n_bad++; $display("FAIL blk_x: got %0d want 101", xdata); end
    n_cmp++; if (ydata !== 9'd51) begin n_bad++; $display("FAIL blk_y: got %0d want 51", ydata); end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL blk_found: got %0b want 1", found); end
    n_cmp++; if (early_chg !== 0 || late_chg !== 0) begin n_bad++; $display("FAIL blk_stable: got %0d/%0d changes want 0/0", early_chg, late_chg); end
    n_cmp++; if (busy_bad !== 0) begin n_bad++; $display("FAIL blk_busy: got %0d bad cycles want 0", busy_bad); end
  endtask

  task automatic test_low_hits();
    int first_upd = -1, n_upd = 0, busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      send_noise();
      send_hit($urandom_range(0, 639), $urandom_range(0, 479));
    end
    frame_end = 1'b1;
    model_close();
    for (int k = 1; k <= 70; k++) begin
      step();
      if (k == 1) frame_end = 1'b0;
      if (upd) begin n_upd++; if (first_upd < 0) first_upd = k; end
      if (busy) busy_seen++;
    end
    n_cmp++; if (first_upd !== 1) begin n_bad++; $display("FAIL low_latency: got %0d want 1", first_upd); end
    n_cmp++; if (n_upd !== 1) begin n_bad++; $display("FAIL low_upd_count: got %0d want 1", n_upd); end
    n_cmp++; if (found !== 1'b0) begin n_bad++; $display("FAIL low_found: got %0b want 0", found); end
    n_cmp++; if (xdata !== 10'(exp_x) || ydata !== 9'(exp_y)) begin n_bad++; $display("FAIL low_hold: got %0d/%0d want %0d/%0d", xdata, ydata, exp_x, exp_y); end
    n_cmp++; if (busy_seen !== 0) begin n_bad++; $display("FAIL low_busy: got %0d busy cycles want 0", busy_seen); end
  endtask

  task automatic test_coincident();
    int first_upd = -1, n_upd = 0;
    for (int i = 0; i < 15; i++) send_hit(200, 100);
    pix_valid = 1'b1;
    pix_hit   = 1'b1;
    pix_x     = 10'd216;
    pix_y     = 9'd100;
    frame_end = 1'b1;
    hx.push_back(216);
    hy.push_back(100);
    model_close();
    for (int k = 1; k <= 70; k++) begin
      step();
      if (k == 1) begin frame_end = 1'b0; pix_valid = 1'b0; pix_hit = 1'b0; end
      if (upd) begin n_upd++; if (first_upd < 0) first_upd = k; end
    end
    n_cmp++; if (first_upd !== LAT || n_upd !== 1) begin n_bad++; $display("FAIL coin_upd: got k=%0d n=%0d want k=%0d n=1", first_upd, n_upd, LAT); end
    n_cmp++; if (xdata !== 10'd201 || ydata !== 9'd100) begin n_bad++; $display("FAIL coin_xy: got %0d/%0d want 201/100", xdata, ydata); end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL coin_found: got %0b want 1", found); end
    // 15 hits next: any hit leaked from the closed frame would lift it to 16.
    first_upd = -1;
    for (int i = 0; i < 15; i++) send_hit($urandom_range(0, 639), $urandom_range(0, 479));
    frame_end = 1'b1;
    model_close();
    for (int k = 1; k <= 70; k++) begin
      step();
      if (k == 1) frame_end = 1'b0;
      if (upd && first_upd < 0) first_upd = k;
    end
    n_cmp++; if (first_upd !== 1 || found !== 1'b0) begin n_bad++; $display("FAIL coin_next_clear: got k=%0d found=%0b want k=1 found=0", first_upd, found); end
    n_cmp++; if (xdata !== 10'd201 || ydata !== 9'd100) begin n_bad++; $display("FAIL coin_next_hold: got %0d/%0d want 201/100", xdata, ydata); end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 6; f++) begin
      int n;
      bit on_fe;
      int first_upd = -1, n_upd = 0;
      n = (f == 0) ? 16 : (f == 1) ? 15 : $urandom_range(0, 40);
      on_fe = $urandom_range(0, 1);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) send_noise();
        if (on_fe && i == n - 1) begin
          pix_valid = 1'b1;
          pix_hit   = 1'b1;
          pix_x     = 10'($urandom_range(0, 639));
          pix_y     = 9'($urandom_range(0, 479));
          hx.push_back(int'(pix_x));
          hy.push_back(int'(pix_y));
        end else begin
          send_hit($urandom_range(0, 639), $urandom_range(0, 479));
        end
      end
      frame_end = 1'b1;
      model_close();
      for (int k = 1; k <= 70; k++) begin
        step();
        if (k == 1) begin frame_end = 1'b0; pix_valid = 1'b0; pix_hit = 1'b0; end
        if (upd) begin n_upd++; if (first_upd < 0) first_upd = k; end
      end
      n_cmp++; if (first_upd !== exp_lat || n_upd !== 1) begin n_bad++; $display("FAIL rnd%0d_upd: got k=%0d n=%0d want k=%0d n=1", f, first_upd, n_upd, exp_lat); end
      n_cmp++; if (xdata !== 10'(exp_x) || ydata !== 9'(exp_y)) begin n_bad++; $display("FAIL rnd%0d_xy: got %0d/%0d want %0d/%0d", f, xdata, ydata, exp_x, exp_y); end
      n_cmp++; if (found !== exp_found) begin n_bad++; $display("FAIL rnd%0d_found: got %0b want %0b", f, found, exp_found); end
    end
  endtask

  task automatic test_overrun();
    int first_upd = -1, n_upd = 0, first_ovr = -1, n_ovr = 0;
    for (int i = 0; i < 20; i++) send_hit($urandom_range(0, 639), $urandom_range(0, 479));
    frame_end = 1'b1;
    model_close();
    for (int k = 1; k <= 80; k++) begin
      step();
      frame_end = (k == 20);
      pix_valid = (k < 20);
      pix_hit   = (k < 20);
      pix_x     = 10'($urandom_range(0, 639));
      pix_y     = 9'($urandom_range(0, 479));
      if (upd) begin n_upd++; if (first_upd < 0) first_upd = k; end
      if (overrun) begin n_ovr++; if (first_ovr < 0) first_ovr = k; end
    end
    n_cmp++; if (first_ovr !== 21 || n_ovr !== 1) begin n_bad++; $display("FAIL ovr_pulse: got k=%0d n=%0d want k=21 n=1", first_ovr, n_ovr); end
    n_cmp++; if (first_upd !== LAT || n_upd !== 1) begin n_bad++; $display("FAIL ovr_upd: got k=%0d n=%0d want k=%0d n=1", first_upd, n_upd, LAT); end
    n_cmp++; if (xdata !== 10'(exp_x) || ydata !== 9'(exp_y) || found !== 1'b1) begin n_bad++; $display("FAIL ovr_result: got %0d/%0d/%0b want %0d/%0d/1", xdata, ydata, found, exp_x, exp_y); end
    // The dropped frame's 19 hits must not carry into this 15-hit frame.
    first_upd = -1;
    for (int i = 0; i < 15; i++) send_hit($urandom_range(0, 639), $urandom_range(0, 479));
    frame_end = 1'b1;
    model_close();
    for (int k = 1; k <= 70; k++) begin
      step();
      if (k == 1) frame_end = 1'b0;
      if (upd && first_upd < 0) first_upd = k;
    end
    n_cmp++; if (first_upd !== 1 || found !== 1'b0) begin n_bad++; $display("FAIL ovr_next_clear: got k=%0d found=%0b want k=1 found=0", first_upd, found); end
  endtask

  task automatic test_reset_mid_divide();
    int n_upd = 0;
    for (int i = 0; i < 24; i++) send_hit($urandom_range(0, 639), $urandom_range(0, 479));
    frame_end = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 1) frame_end = 1'b0;
    end
    hx.delete();
    hy.delete();
    exp_x = 320;
    exp_y = 240;
    exp_found = 1'b0;
    reset = 1'b1;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %0b want 0", busy); end
    n_cmp++; if (xdata !== 10'(exp_x) || ydata !== 9'(exp_y) || found !== exp_found) begin n_bad++; $display("FAIL mid_outputs: got %0d/%0d/%0b want 320/240/0", xdata, ydata, found); end
    reset = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (upd) n_upd++;
    end
    n_cmp++; if (n_upd !== 0) begin n_bad++; $display("FAIL mid_no_upd: got %0d want 0", n_upd); end
  endtask

  initial begin
    test_reset();
    test_block_centroid();
    test_low_hits();
    test_coincident();
    test_random_frames();
    test_overrun();
    test_reset_mid_divide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
